// File: rtl/seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_restoring_divider
// Description : Multi-cycle unsigned restoring divider. Produces the quotient
//               and remainder of dividend / divisor, retiring one quotient bit
//               per clock through a ripple chain of full-subtractor cells.
//               A start/busy/done handshake connects it to the controlling
//               FSM of the arithmetic datapath.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        operand / result width in bits (>= 2)
// Ports
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      synchronous active-low reset
//   start        in   1      request, sampled only in IDLE or DONE
//   dividend     in   WIDTH  numerator, latched when start is accepted
//   divisor      in   WIDTH  denominator, latched when start is accepted
//   busy         out  1      high while a division is iterating
//   done         out  1      one-cycle pulse, results valid in that cycle
//   quotient     out  WIDTH  registered quotient (all ones on divide by 0)
//   remainder    out  WIDTH  registered remainder (dividend on divide by 0)
//   div_by_zero  out  1      set together with done when divisor was 0
// ============================================================================
module seq_restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   localparam int                 c_CNT_W   = $clog2(WIDTH + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_LAST    = c_CNT_W'(WIDTH - 1);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   logic [1:0]         r_state;
   logic [1:0]         w_state_next;

   logic [WIDTH-1:0]   r_divisor;   // operand isolated from the input port
   logic [WIDTH-1:0]   r_rem;       // partial remainder
   logic [WIDTH-1:0]   r_q;         // dividend shifting out, quotient in
   logic [c_CNT_W-1:0] r_cnt;       // iteration index within RUN

   // ------------------------------------------------------------------------
   // Control decode
   // ------------------------------------------------------------------------
   logic w_idle_like;
   logic w_accept;
   logic w_div_zero;
   logic w_last;

   // Both IDLE and DONE take a new request, which allows back-to-back use.
   assign w_idle_like = (r_state == c_IDLE) || (r_state == c_DONE);
   assign w_accept    = start && w_idle_like;
   assign w_div_zero  = (divisor == '0);
   assign w_last      = (r_cnt == c_LAST);

   // ------------------------------------------------------------------------
   // Trial subtraction: {rem, next dividend bit} - {0, divisor}
   //
   // The partial remainder is held as WIDTH bits: after every iteration it
   // is strictly less than the divisor, so the (WIDTH+1)-bit working value
   // always has a zero MSB once stored. The MSB of the shifted operand is
   // still fed through the chain so the final borrow is exact.
   // ------------------------------------------------------------------------
   logic [WIDTH:0]   w_a;
   logic [WIDTH:0]   w_b;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH+1:0] w_borrow;
   logic             w_no_borrow;
   logic [WIDTH-1:0] w_rem_next;
   logic [WIDTH-1:0] w_q_next;

   assign w_a         = {r_rem, r_q[WIDTH-1]};
   assign w_b         = {1'b0, r_divisor};
   assign w_borrow[0] = 1'b0;

   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_sub
         assign w_diff[i]     = w_a[i] ^ w_b[i] ^ w_borrow[i];
         assign w_borrow[i+1] = (~w_a[i] & w_b[i])
                              | (~(w_a[i] ^ w_b[i]) & w_borrow[i]);
      end
   endgenerate

   // Top cell: only its borrow matters, its difference bit is always 0
   // whenever the subtraction is kept.
   assign w_borrow[WIDTH+1] = (~w_a[WIDTH] & w_b[WIDTH])
                            | (~(w_a[WIDTH] ^ w_b[WIDTH]) & w_borrow[WIDTH]);

   assign w_no_borrow = ~w_borrow[WIDTH+1];

   // Keep the difference when it did not go negative, else restore.
   assign w_rem_next  = w_no_borrow ? w_diff : w_a[WIDTH-1:0];
   assign w_q_next    = {r_q[WIDTH-2:0], w_no_borrow};

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_accept) begin
               w_state_next = w_div_zero ? c_DONE : c_RUN;
            end
         end
         c_RUN: begin
            // start is ignored here; only the iteration count moves us on.
            if (w_last) begin
               w_state_next = c_DONE;
            end
         end
         c_DONE: begin
            if (w_accept) begin
               w_state_next = w_div_zero ? c_DONE : c_RUN;
            end else begin
               w_state_next = c_IDLE;
            end
         end
         default: begin
            w_state_next = c_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         c_RUN:   busy = 1'b1;
         c_DONE:  done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath and result registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_divisor   <= '0;
         r_rem       <= '0;
         r_q         <= '0;
         r_cnt       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (w_accept) begin
         r_divisor <= divisor;
         r_rem     <= '0;
         r_q       <= dividend;
         r_cnt     <= '0;
         if (w_div_zero) begin
            // Skip the iterations entirely; results appear with done next
            // cycle.
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end else begin
            div_by_zero <= 1'b0;
         end
      end else if (r_state == c_RUN) begin
         r_rem <= w_rem_next;
         r_q   <= w_q_next;
         r_cnt <= r_cnt + c_CNT_ONE;
         // Results only move on the final iteration so the visible
         // outputs stay stable for the whole RUN phase.
         if (w_last) begin
            quotient  <= w_q_next;
            remainder <= w_rem_next;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_restoring_divider
// Description : Self-checking bench for seq_restoring_divider (WIDTH = 4).
//               Expected results come from plain integer division.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_restoring_divider;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   int tests = 0;
   int fails = 0;

   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] prev_r;

   always #5 clk = ~clk;

   seq_restoring_divider #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step();
      chk("idle done", done, 1'b0);
      chk("idle busy", busy, 1'b0);
   endtask

   // Issues a/b from the current cycle (DUT in IDLE or DONE), then follows
   // the operation to its done cycle. inject_at / rst_at (RUN cycle index,
   // -1 for none) pulse a stray start or a reset during RUN.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int inject_at, input int rst_at);
      logic [WIDTH-1:0] eq;
      logic [WIDTH-1:0] er;
      int               lat;
      int               exp_lat;
      eq      = (b == 0) ? {WIDTH{1'b1}} : WIDTH'(a / b);
      er      = (b == 0) ? a : WIDTH'(a % b);
      exp_lat = (b == 0) ? 0 : WIDTH;

      start    = 1'b1;
      dividend = a;
      divisor  = b;
      step();
      start    = 1'b0;
      dividend = WIDTH'($urandom);
      divisor  = WIDTH'($urandom);

      lat = 0;
      while (done !== 1'b1 && lat < 3 * WIDTH) begin
         chk("busy in RUN", busy, 1'b1);
         chk("quotient hold", quotient, prev_q);
         chk("remainder hold", remainder, prev_r);
         if (lat == rst_at) begin
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            chk("rst busy", busy, 1'b0);
            chk("rst done", done, 1'b0);
            chk("rst quotient", quotient, 0);
            chk("rst remainder", remainder, 0);
            chk("rst div_by_zero", div_by_zero, 1'b0);
            for (int k = 0; k < WIDTH + 1; k++) begin
               step();
               chk("post-rst no done", done, 1'b0);
               chk("post-rst no busy", busy, 1'b0);
            end
            prev_q = '0;
            prev_r = '0;
            return;
         end
         if (lat == inject_at) begin
            start    = 1'b1;
            dividend = 1;
            divisor  = 1;
         end
         step();
         start = 1'b0;
         lat++;
      end

      chk("done edges after accept", lat, exp_lat);
      chk("busy with done", busy, 1'b0);
      chk("quotient", quotient, eq);
      chk("remainder", remainder, er);
      chk("div_by_zero", div_by_zero, (b == 0));
      prev_q = eq;
      prev_r = er;
   endtask

   initial begin
      int gap;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      prev_q   = '0;
      prev_r   = '0;
      step();
      step();
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset quotient", quotient, 0);
      chk("reset remainder", remainder, 0);
      chk("reset div_by_zero", div_by_zero, 1'b0);
      rst_n = 1'b1;
      idle();

      // Basic operation
      issue(4'd13, 4'd3, -1, -1);
      idle();

      // Back-to-back: each new start is raised in the previous DONE cycle
      issue(4'd7, 4'd9, -1, -1);
      issue(4'd15, 4'd1, -1, -1);
      issue(4'd15, 4'd15, -1, -1);
      idle();

      // Divide by zero, then a normal divide clears the flag
      issue(4'd9, 4'd0, -1, -1);
      issue(4'd12, 4'd4, -1, -1);
      idle();

      // Stray start with new operands in the 2nd RUN cycle is ignored
      issue(4'd14, 4'd5, 1, -1);
      idle();

      // Reset in the 3rd RUN cycle, then a clean retry
      issue(4'd11, 4'd2, -1, 2);
      issue(4'd11, 4'd2, -1, -1);
      idle();

      // Exhaustive sweep
      for (int a = 0; a < (1 << WIDTH); a++) begin
         for (int b = 0; b < (1 << WIDTH); b++) begin
            issue(WIDTH'(a), WIDTH'(b), -1, -1);
            idle();
         end
      end

      // Random operands with random gaps (gap 0 = back-to-back)
      repeat (60) begin
         issue(WIDTH'($urandom), WIDTH'($urandom_range(0, 3) == 0 ? 0 : $urandom), -1, -1);
         gap = $urandom_range(0, 2);
         if (gap == 0) begin
            continue;
         end
         repeat (gap) idle();
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
